// File: rtl/plant_sequencer.sv
// ---------------------------------------------------------------------------
// plant_sequencer
//
// Wishbone-controlled drive/wait/sample sequencer for a small plant.
// A run drives an 8-bit pattern onto pads [23:16], waits a programmable
// number of cycles, then samples pads [15:8]. Runs repeat while CONT is set.
//
// Register map (byte address = BASE_ADDR + 4*index):
//   0 CTRL    : [0] START (W1, reads 0) [1] CONT [2] IRQ_EN [3] ABORT (W1, reads 0)
//   1 PERIOD  : [15:0] wait-cycle count
//   2 PATTERN : [7:0] drive value
//   3 STATUS  : [1:0] state, [2] DONE (W1C), [15:8] last sample, [31:16] runs
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone classic handshake
//   wbs_sel_i, wbs_adr_i        byte lanes, byte address
//   wbs_dat_i / wbs_dat_o       write / read data
//   wbs_ack_o                   single-cycle transfer acknowledge
//   io_in, io_out, io_oeb       pad in / pad out / pad enable (active-low)
//   user_irq                    [0] = DONE & IRQ_EN, others tied low
// ---------------------------------------------------------------------------
module plant_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic [2:0]  user_irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  state_t      state;
  logic [15:0] wait_cnt;
  logic [7:0]  pat_q;
  logic [7:0]  sample;
  logic [15:0] run_cnt;
  logic        done;

  logic        ctrl_cont;
  logic        ctrl_irq_en;
  logic [15:0] period;
  logic [7:0]  pattern;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic       bus_sel;
  logic [1:0] reg_idx;
  logic       wr_en;
  logic       wr_ctrl;
  logic       start_req;
  logic       abort_req;
  logic       done_clr;

  assign bus_sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx = wbs_adr_i[3:2];

  // A classic master holds its request through the ack cycle, so the write
  // commits on the edge that closes the ack cycle.
  assign wr_en     = wbs_ack_o & bus_sel & wbs_we_i;
  assign wr_ctrl   = wr_en & (reg_idx == REG_CTRL) & wbs_sel_i[0];
  assign start_req = wr_ctrl & wbs_dat_i[0];
  assign abort_req = wr_ctrl & wbs_dat_i[3];
  assign done_clr  = wr_en & (reg_idx == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];

  logic [31:0] rd_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    rd_data = 32'd0;
    case (reg_idx)
      REG_CTRL:    rd_data = {29'd0, ctrl_irq_en, ctrl_cont, 1'b0};
      REG_PERIOD:  rd_data = {16'd0, period};
      REG_PATTERN: rd_data = {24'd0, pattern};
      REG_STATUS:  rd_data = {run_cnt, sample, 5'd0, done, state};
      default:     rd_data = 32'd0;
    endcase
  end

  // Ack toggles off after every acknowledged beat, so a held strobe sees an
  // ack on every other cycle.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= bus_sel & ~wbs_ack_o;
      wbs_dat_o <= (bus_sel & ~wbs_ack_o) ? rd_data : 32'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Configuration registers
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_cont   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      period      <= 16'd0;
      pattern     <= 8'd0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_CTRL: begin
          if (wbs_sel_i[0]) begin
            ctrl_cont   <= wbs_dat_i[1];
            ctrl_irq_en <= wbs_dat_i[2];
          end
        end
        REG_PERIOD: begin
          if (wbs_sel_i[0]) period[7:0]  <= wbs_dat_i[7:0];
          if (wbs_sel_i[1]) period[15:8] <= wbs_dat_i[15:8];
        end
        REG_PATTERN: begin
          if (wbs_sel_i[0]) pattern <= wbs_dat_i[7:0];
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // Pattern and wait count are captured on entry to DRIVE so the pattern is
  // already on the pads during the DRIVE cycle, and register writes made
  // mid-run only show up on the following DRIVE.
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= 16'd0;
      pat_q    <= 8'd0;
      sample   <= 8'd0;
      run_cnt  <= 16'd0;
      done     <= 1'b0;
    end else begin
      // NOTE: the SAMPLE branch below may also assign done; the later
      // non-blocking assignment wins, giving set priority over clear.
      if (done_clr) done <= 1'b0;

      if (abort_req && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_req && !abort_req) begin
              state    <= ST_DRIVE;
              pat_q    <= pattern;
              wait_cnt <= period;
            end
          end
          ST_DRIVE: begin
            state <= (wait_cnt == 16'd0) ? ST_SAMPLE : ST_WAIT;
          end
          ST_WAIT: begin
            wait_cnt <= wait_cnt - 16'd1;
            if (wait_cnt == 16'd1) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            sample <= io_in[15:8];
            if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
            if (ctrl_cont) begin
              state    <= ST_DRIVE;
              pat_q    <= pattern;
              wait_cnt <= period;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pads and interrupt
  // -------------------------------------------------------------------------
  assign io_out   = {14'd0, pat_q, 16'd0};
  assign io_oeb   = {{14{1'b1}}, (state == ST_IDLE) ? 8'hFF : 8'h00, 16'hFFFF};
  assign user_irq = {2'b00, done & ctrl_irq_en};

  // Inputs that the register map does not consume.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, io_in[37:16], io_in[7:0], wbs_adr_i[1:0],
                           wbs_dat_i[31:16], wbs_sel_i[3:2]};

endmodule
